// File: rtl/branch_update_queue_if.sv
// Enqueue/dequeue bus between the execution lanes, the branch update queue
// and the predictor update port.
`timescale 1ns/1ps
interface branch_update_queue_if #(
  parameter int unsigned ENQ_WIDTH  = 2,
  parameter int unsigned DEQ_WIDTH  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned HIST_WIDTH = 10,
  parameter int unsigned CTR_WIDTH  = 2
) ();

  // Resolved branches from the integer issue lanes
  logic [ENQ_WIDTH-1:0]                 enq_valid;
  logic [ENQ_WIDTH-1:0][ADDR_WIDTH-1:0] enq_addr;
  logic [ENQ_WIDTH-1:0]                 enq_is_cond;
  logic [ENQ_WIDTH-1:0]                 enq_pred_taken;
  logic [ENQ_WIDTH-1:0]                 enq_exec_taken;
  logic [ENQ_WIDTH-1:0][HIST_WIDTH-1:0] enq_hist;
  logic [ENQ_WIDTH-1:0][CTR_WIDTH-1:0]  enq_ctr;
  logic                                 enq_ready;

  // Training updates towards the predictor
  logic [DEQ_WIDTH-1:0]                 deq_valid;
  logic [DEQ_WIDTH-1:0][ADDR_WIDTH-1:0] deq_addr;
  logic [DEQ_WIDTH-1:0]                 deq_is_cond;
  logic [DEQ_WIDTH-1:0]                 deq_exec_taken;
  logic [DEQ_WIDTH-1:0]                 deq_mispred;
  logic [DEQ_WIDTH-1:0][HIST_WIDTH-1:0] deq_hist;
  logic [DEQ_WIDTH-1:0][HIST_WIDTH-1:0] deq_new_hist;
  logic [DEQ_WIDTH-1:0][CTR_WIDTH-1:0]  deq_new_ctr;
  logic                                 deq_ready;

  modport master (
    output enq_valid, enq_addr, enq_is_cond, enq_pred_taken, enq_exec_taken,
           enq_hist, enq_ctr, deq_ready,
    input  enq_ready, deq_valid, deq_addr, deq_is_cond, deq_exec_taken,
           deq_mispred, deq_hist, deq_new_hist, deq_new_ctr
  );

  modport slave (
    input  enq_valid, enq_addr, enq_is_cond, enq_pred_taken, enq_exec_taken,
           enq_hist, enq_ctr, deq_ready,
    output enq_ready, deq_valid, deq_addr, deq_is_cond, deq_exec_taken,
           deq_mispred, deq_hist, deq_new_hist, deq_new_ctr
  );

endinterface

// File: rtl/branch_update_queue.sv
// Circular queue of resolved branches feeding predictor training updates,
// with at most one mispredict (history recovery) delivered per cycle.
`timescale 1ns/1ps
module branch_update_queue #(
  parameter int unsigned ENQ_WIDTH  = 2,
  parameter int unsigned DEQ_WIDTH  = 2,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned HIST_WIDTH = 10,
  parameter int unsigned CTR_WIDTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  branch_update_queue_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              mispred_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned MCNT_W = 16;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [CNT_W-1:0]     READY_MAX = CNT_W'(DEPTH - ENQ_WIDTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  is_cond;
    logic                  pred_taken;
    logic                  exec_taken;
    logic [HIST_WIDTH-1:0] hist;
    logic [CTR_WIDTH-1:0]  ctr;
  } entry_t;

  entry_t               mem_q [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 enq_ready_q;
  logic                 overflow_q, overflow_d;
  logic [MCNT_W-1:0]    mcnt_q, mcnt_d;

  logic                              do_enq;
  logic [CNT_W-1:0]                  n_acc;
  logic [ENQ_WIDTH-1:0][PTR_W-1:0]   wr_ptr;
  entry_t                            rd_e [DEQ_WIDTH];
  logic [DEQ_WIDTH-1:0]              rd_mis;
  logic [DEQ_WIDTH-1:0]              deq_vld;
  logic [CNT_W-1:0]                  n_pop;
  logic [CNT_W-1:0]                  n_mis;
  logic [MCNT_W:0]                   mis_sum;

  // Accepted lanes pack densely from the tail in ascending lane order
  always_comb begin
    do_enq = enq_ready_q && !flush;
    n_acc  = '0;
    wr_ptr = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      wr_ptr[i] = tail_q + n_acc[PTR_W-1:0];
      if (bus.enq_valid[i]) n_acc = n_acc + CNT_W'(1);
    end
    if (!do_enq) n_acc = '0;
  end

  // Payload storage carries no reset; only slots below count are ever shown valid
  always_ff @(posedge clk) begin
    if (!rst && do_enq) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (bus.enq_valid[i]) begin
          mem_q[wr_ptr[i]] <= '{addr:       bus.enq_addr[i],
                                is_cond:    bus.enq_is_cond[i],
                                pred_taken: bus.enq_pred_taken[i],
                                exec_taken: bus.enq_exec_taken[i],
                                hist:       bus.enq_hist[i],
                                ctr:        bus.enq_ctr[i]};
        end
      end
    end
  end

  // Head window read and per-entry mispredict classification
  always_comb begin
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      rd_e[k]   = mem_q[head_q + PTR_W'(k)];
      rd_mis[k] = rd_e[k].is_cond ? (rd_e[k].pred_taken != rd_e[k].exec_taken)
                                  : (!rd_e[k].pred_taken && rd_e[k].exec_taken);
    end
  end

  // Lanes after the first mispredict are held back to the next cycle
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    deq_vld = '0;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      deq_vld[k] = (count_q > CNT_W'(k)) && !blocked;
      if (deq_vld[k] && rd_mis[k]) blocked = 1'b1;
    end
  end

  // Predictor update payload: trained history and saturating counter
  always_comb begin
    bus.deq_valid      = deq_vld;
    bus.deq_addr       = '0;
    bus.deq_is_cond    = '0;
    bus.deq_exec_taken = '0;
    bus.deq_mispred    = '0;
    bus.deq_hist       = '0;
    bus.deq_new_hist   = '0;
    bus.deq_new_ctr    = '0;
    for (int k = 0; k < DEQ_WIDTH; k++) begin
      bus.deq_addr[k]       = rd_e[k].addr;
      bus.deq_is_cond[k]    = rd_e[k].is_cond;
      bus.deq_exec_taken[k] = rd_e[k].exec_taken;
      bus.deq_mispred[k]    = rd_mis[k];
      bus.deq_hist[k]       = rd_e[k].hist;
      if (rd_e[k].is_cond) begin
        bus.deq_new_hist[k] = {rd_e[k].hist[HIST_WIDTH-2:0], rd_e[k].exec_taken};
        if (rd_e[k].exec_taken) begin
          bus.deq_new_ctr[k] = (rd_e[k].ctr == CTR_MAX) ? rd_e[k].ctr
                                                        : rd_e[k].ctr + CTR_WIDTH'(1);
        end else begin
          bus.deq_new_ctr[k] = (rd_e[k].ctr == '0) ? rd_e[k].ctr
                                                   : rd_e[k].ctr - CTR_WIDTH'(1);
        end
      end else begin
        bus.deq_new_hist[k] = rd_e[k].hist;
        bus.deq_new_ctr[k]  = rd_e[k].ctr;
      end
    end
  end

  // Pop and mispredict tallies; a flush suppresses both
  always_comb begin
    n_pop = '0;
    n_mis = '0;
    if (bus.deq_ready && !flush) begin
      for (int k = 0; k < DEQ_WIDTH; k++) begin
        if (deq_vld[k]) n_pop = n_pop + CNT_W'(1);
        if (deq_vld[k] && rd_mis[k]) n_mis = n_mis + CNT_W'(1);
      end
    end
  end

  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q;
    mcnt_d     = mcnt_q;
    mis_sum    = {1'b0, mcnt_q} + (MCNT_W+1)'(n_mis);
    if (|bus.enq_valid && !enq_ready_q) overflow_d = 1'b1;
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + n_acc - n_pop;
      head_d  = head_q + n_pop[PTR_W-1:0];
      tail_d  = tail_q + n_acc[PTR_W-1:0];
      mcnt_d  = mis_sum[MCNT_W] ? '1 : mis_sum[MCNT_W-1:0];
    end
  end

  // enq_ready is registered from next occupancy, so it never sees same-cycle pops
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      enq_ready_q <= 1'b1;
      overflow_q  <= 1'b0;
      mcnt_q      <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      enq_ready_q <= (count_d <= READY_MAX);
      overflow_q  <= overflow_d;
      mcnt_q      <= mcnt_d;
    end
  end

  assign bus.enq_ready = enq_ready_q;
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign mispred_cnt   = mcnt_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue with hand-computed expectations.
`timescale 1ns/1ps
module tb_branch_update_queue;

  localparam int unsigned EW = 2;
  localparam int unsigned DW = 2;
  localparam int unsigned DP = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned HW = 10;
  localparam int unsigned CW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] mispred_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  branch_update_queue_if #(.ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .ADDR_WIDTH(AW),
                           .HIST_WIDTH(HW), .CTR_WIDTH(CW)) bus ();

  branch_update_queue #(.ENQ_WIDTH(EW), .DEQ_WIDTH(DW), .DEPTH(DP),
                        .ADDR_WIDTH(AW), .HIST_WIDTH(HW), .CTR_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .count       (count),
    .overflow    (overflow),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [31:0] a, input logic c, input logic p,
                          input logic e, input logic [9:0] h, input logic [1:0] ct);
    bus.enq_valid[i]      = 1'b1;
    bus.enq_addr[i]       = a;
    bus.enq_is_cond[i]    = c;
    bus.enq_pred_taken[i] = p;
    bus.enq_exec_taken[i] = e;
    bus.enq_hist[i]       = h;
    bus.enq_ctr[i]        = ct;
  endtask

  task automatic clr_enq();
    bus.enq_valid = '0;
  endtask

  function automatic logic [31:0] seq_addr(input int n);
    return 32'h1000 + 32'(n) * 32'd4;
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.deq_ready = 1'b0;
    bus.enq_valid = '0;
    bus.enq_addr = '0;
    bus.enq_is_cond = '0;
    bus.enq_pred_taken = '0;
    bus.enq_exec_taken = '0;
    bus.enq_hist = '0;
    bus.enq_ctr = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);

    // Two correctly predicted taken conditionals
    set_lane(0, 32'h100, 1'b1, 1'b1, 1'b1, 10'h001, 2'b10);
    set_lane(1, 32'h104, 1'b1, 1'b1, 1'b1, 10'h001, 2'b10);
    step();
    clr_enq();
    check("b2_deq_valid", 64'(bus.deq_valid), 64'h3);
    check("b2_new_ctr0", 64'(bus.deq_new_ctr[0]), 64'h3);
    check("b2_new_ctr1", 64'(bus.deq_new_ctr[1]), 64'h3);
    check("b2_new_hist0", 64'(bus.deq_new_hist[0]), 64'h003);
    check("b2_hist0", 64'(bus.deq_hist[0]), 64'h001);
    check("b2_is_cond0", 64'(bus.deq_is_cond[0]), 64'h1);
    check("b2_exec0", 64'(bus.deq_exec_taken[0]), 64'h1);
    check("b2_mispred", 64'(bus.deq_mispred), 64'h0);
    check("b2_addr0", 64'(bus.deq_addr[0]), 64'h100);
    check("b2_addr1", 64'(bus.deq_addr[1]), 64'h104);
    check("b2_count", 64'(count), 64'd2);
    bus.deq_ready = 1'b1;
    step();
    bus.deq_ready = 1'b0;
    check("b2_pop_count", 64'(count), 64'd0);
    check("b2_pop_valid", 64'(bus.deq_valid), 64'd0);

    // Mispredicted head blocks the following lane
    set_lane(0, 32'h200, 1'b1, 1'b1, 1'b0, 10'h155, 2'b00);
    set_lane(1, 32'h204, 1'b1, 1'b0, 1'b0, 10'h2AA, 2'b01);
    step();
    clr_enq();
    check("mp_deq_valid", 64'(bus.deq_valid), 64'h1);
    check("mp_mispred0", 64'(bus.deq_mispred[0]), 64'h1);
    check("mp_new_ctr0", 64'(bus.deq_new_ctr[0]), 64'h0);
    check("mp_new_hist0", 64'(bus.deq_new_hist[0]), 64'h2AA);
    bus.deq_ready = 1'b1;
    step();
    check("mp_second_addr", 64'(bus.deq_addr[0]), 64'h204);
    check("mp_second_valid", 64'(bus.deq_valid), 64'h1);
    check("mp_second_ctr", 64'(bus.deq_new_ctr[0]), 64'h0);
    check("mp_second_hist", 64'(bus.deq_new_hist[0]), 64'h154);
    check("mp_cnt1", 64'(mispred_cnt), 64'd1);
    check("mp_count1", 64'(count), 64'd1);
    step();
    bus.deq_ready = 1'b0;
    check("mp_drain_count", 64'(count), 64'd0);
    check("mp_drain_cnt", 64'(mispred_cnt), 64'd1);

    // Non-conditional entries: taken-but-predicted-not is a mispredict, fields pass through
    set_lane(0, 32'h300, 1'b0, 1'b0, 1'b1, 10'h0F0, 2'b01);
    set_lane(1, 32'h304, 1'b0, 1'b1, 1'b0, 10'h0F0, 2'b11);
    step();
    clr_enq();
    check("nc_deq_valid", 64'(bus.deq_valid), 64'h1);
    check("nc_mispred0", 64'(bus.deq_mispred[0]), 64'h1);
    check("nc_new_hist0", 64'(bus.deq_new_hist[0]), 64'h0F0);
    check("nc_new_ctr0", 64'(bus.deq_new_ctr[0]), 64'h1);
    bus.deq_ready = 1'b1;
    step();
    check("nc_lane1_valid", 64'(bus.deq_valid), 64'h1);
    check("nc_lane1_mispred", 64'(bus.deq_mispred[0]), 64'h0);
    check("nc_lane1_ctr", 64'(bus.deq_new_ctr[0]), 64'h3);
    check("nc_cnt2", 64'(mispred_cnt), 64'd2);
    step();
    bus.deq_ready = 1'b0;
    check("nc_drain_count", 64'(count), 64'd0);

    // Fill to 7 without popping, then overflow
    for (int c = 0; c < 3; c++) begin
      set_lane(0, 32'h400 + 32'(c) * 32'd8, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
      set_lane(1, 32'h404 + 32'(c) * 32'd8, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
      step();
    end
    clr_enq();
    set_lane(0, 32'h418, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    step();
    clr_enq();
    check("fill_count7", 64'(count), 64'd7);
    check("fill_enq_ready", 64'(bus.enq_ready), 64'd0);
    check("fill_deq_valid", 64'(bus.deq_valid), 64'h3);
    set_lane(0, 32'h500, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    set_lane(1, 32'h504, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    step();
    clr_enq();
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_count", 64'(count), 64'd7);
    check("ovf_head_stable", 64'(bus.deq_addr[0]), 64'h400);
    bus.deq_ready = 1'b1;
    repeat (4) step();
    bus.deq_ready = 1'b0;
    check("ovf_drain_count", 64'(count), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Steady 2-in/2-out across pointer wrap
    set_lane(0, seq_addr(0), 1'b1, 1'b1, 1'b1, 10'h000, 2'b11);
    set_lane(1, seq_addr(1), 1'b1, 1'b1, 1'b1, 10'h000, 2'b11);
    step();
    check("wrap_sat_ctr", 64'(bus.deq_new_ctr[0]), 64'h3);
    bus.deq_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_lane(0, seq_addr(2 + 2 * i), 1'b1, 1'b1, 1'b1, 10'h000, 2'b11);
      set_lane(1, seq_addr(3 + 2 * i), 1'b1, 1'b1, 1'b1, 10'h000, 2'b11);
      step();
      check("wrap_count", 64'(count), 64'd2);
      check("wrap_addr0", 64'(bus.deq_addr[0]), 64'(seq_addr(2 + 2 * i)));
      check("wrap_addr1", 64'(bus.deq_addr[1]), 64'(seq_addr(3 + 2 * i)));
    end
    clr_enq();
    step();
    bus.deq_ready = 1'b0;
    check("wrap_drain", 64'(count), 64'd0);

    // Flush at count 5 with same-cycle enqueue and a pop of a mispredicted head
    set_lane(0, 32'h600, 1'b1, 1'b1, 1'b0, 10'h000, 2'b01);
    set_lane(1, 32'h604, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    step();
    set_lane(0, 32'h608, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    set_lane(1, 32'h60C, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    step();
    clr_enq();
    set_lane(0, 32'h610, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    step();
    check("fl_pre_count", 64'(count), 64'd5);
    check("fl_pre_valid", 64'(bus.deq_valid), 64'h1);
    flush = 1'b1;
    bus.deq_ready = 1'b1;
    set_lane(0, 32'h700, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    set_lane(1, 32'h704, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
    step();
    flush = 1'b0;
    bus.deq_ready = 1'b0;
    clr_enq();
    check("fl_count", 64'(count), 64'd0);
    check("fl_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("fl_mispred_cnt", 64'(mispred_cnt), 64'd2);
    check("fl_overflow_kept", 64'(overflow), 64'd1);
    check("fl_enq_ready", 64'(bus.enq_ready), 64'd1);

    // Mid-stream reset at count 4, with enqueue in the same cycle
    for (int c = 0; c < 2; c++) begin
      set_lane(0, 32'h800 + 32'(c) * 32'd8, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
      set_lane(1, 32'h804 + 32'(c) * 32'd8, 1'b1, 1'b1, 1'b1, 10'h000, 2'b01);
      step();
    end
    check("mr_pre_count", 64'(count), 64'd4);
    rst = 1'b1;
    bus.deq_ready = 1'b1;
    step();
    rst = 1'b0;
    bus.deq_ready = 1'b0;
    clr_enq();
    check("mr_count", 64'(count), 64'd0);
    check("mr_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("mr_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("mr_overflow", 64'(overflow), 64'd0);
    check("mr_mispred_cnt", 64'(mispred_cnt), 64'd0);
    set_lane(0, 32'hABC, 1'b1, 1'b0, 1'b0, 10'h000, 2'b01);
    step();
    clr_enq();
    check("mr_post_valid", 64'(bus.deq_valid), 64'h1);
    check("mr_post_addr", 64'(bus.deq_addr[0]), 64'hABC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
